// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory access unit.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   // funct3 access-size encodings for loads and stores.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte enables; bit0 selects the byte at the even address.
   localparam logic [1:0] BE_LO  = 2'b01;
   localparam logic [1:0] BE_HI  = 2'b10;
   localparam logic [1:0] BE_ALL = 2'b11;

   // Halfword accesses are the ones with funct3[0] set (H, HU).
   function automatic logic is_half(input logic [2:0] f3);
      return f3[0];
   endfunction

   // A request is legal when it is exactly one of load/store, uses a
   // supported size (unsigned sizes only for loads) and halfwords are aligned.
   function automatic logic req_legal(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] f3,
                                      input logic       a0);
      logic ok;
      ok = 1'b0;
      if (!(rd && wr)) begin
         case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !a0;
            F3_BU:   ok = rd;
            F3_HU:   ok = rd && !a0;
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Handshaked data-memory port: the access unit is master, the memory is slave.
interface dmem_access_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-2:0] mem_addr;
   logic [1:0]        mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte lane of a 16-bit memory word and extends it
// according to the load size; shared with the writeback path.
module load_align
   import dmem_pkg::*;
(
   input  logic [15:0] mem_rdata,
   input  logic [2:0]  funct3,
   input  logic        addr_lsb,
   output logic [15:0] load_data
);

   logic [7:0] lane;

   // Pick the byte lane, then sign/zero-extend bytes; halfwords pass through.
   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      lane      = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
      load_data = mem_rdata;
      case (funct3)
         F3_B:    load_data = {{8{lane[7]}}, lane};
         F3_BU:   load_data = {8'h00, lane};
         default: load_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Turns a single-cycle load/store request into a handshaked memory
// transaction, stalls the pipeline until it completes, and reports faults.
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [2:0]         funct3,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               stall,
   output logic               done,
   output logic               fault,
   dmem_access_unit_if.master mem
);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              a0_q, a0_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
   logic [1:0]        mem_be_q, mem_be_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              fault_q, fault_d;
   logic [DATA_W-1:0] load_data;

   load_align u_load_align (
      .mem_rdata (mem.mem_rdata),
      .funct3    (f3_q),
      .addr_lsb  (a0_q),
      .load_data (load_data)
   );

   // Next-state, bus setup and result capture for the IDLE/REQ/RESP sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      f3_d        = f3_q;
      a0_d        = a0_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      fault_d     = 1'b0;
      stall       = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               stall = 1'b1;
               f3_d  = funct3;
               a0_d  = addr[0];
               if (req_legal(mem_read, mem_write, funct3, addr[0])) begin
                  state_d    = REQ;
                  cnt_d      = '0;
                  mem_req_d  = 1'b1;
                  mem_we_d   = mem_write;
                  mem_addr_d = addr[ADDR_W-1:1];
                  if (mem_write && !is_half(funct3)) begin
                     mem_be_d    = addr[0] ? BE_HI : BE_LO;
                     mem_wdata_d = {wdata[7:0], wdata[7:0]};
                  end else begin
                     mem_be_d    = BE_ALL;
                     mem_wdata_d = mem_write ? wdata : '0;
                  end
               end else begin
                  // Illegal request: report it without touching memory.
                  state_d = RESP;
                  fault_d = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         REQ: begin
            stall     = 1'b1;
            mem_req_d = 1'b1;
            if (mem.mem_ack) begin
               // An ack on the timeout cycle still completes cleanly.
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (!mem_we_q) rdata_d = load_data;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               rdata_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered state, bus outputs and result, cleared by synchronous reset.
   // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         a0_q        <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f3_q        <= f3_d;
         a0_q        <= a0_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
      end
   end

   assign done          = (state_q == RESP);
   assign fault         = fault_q;
   assign rdata         = rdata_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a scoreboard holds the expected
// completion of each request and is checked when done pulses.
module tb_dmem_access_unit;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [15:0] addr, wdata;
   logic [15:0] rdata;
   logic        stall, done, fault;

   dmem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

   dmem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .done      (done),
      .fault     (fault),
      .mem       (mem_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic        fault;
      logic        chk_rdata;
   } exp_t;

   exp_t sb[$];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   int          req_cycles, stall_cycles, lat;
   logic        bus_we;
   logic [1:0]  bus_be;
   logic [14:0] bus_addr;
   logic [15:0] bus_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"},     32'(rdata), 0);
      check({tag, "_stall"},     32'(stall), 0);
      check({tag, "_done"},      32'(done), 0);
      check({tag, "_fault"},     32'(fault), 0);
      check({tag, "_mem_req"},   32'(mem_if.mem_req), 0);
      check({tag, "_mem_we"},    32'(mem_if.mem_we), 0);
      check({tag, "_mem_addr"},  32'(mem_if.mem_addr), 0);
      check({tag, "_mem_be"},    32'(mem_if.mem_be), 0);
      check({tag, "_mem_wdata"}, 32'(mem_if.mem_wdata), 0);
   endtask

   // Drive one request, act as the memory (ack on REQ cycle ack_at, -1 = never),
   // and compare the completion against the scoreboard entry pushed here.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [15:0] a, input logic [15:0] wd,
                         input int ack_at, input logic [15:0] bus_rd,
                         input logic [15:0] exp_rdata, input logic exp_fault,
                         input logic chk_rdata);
      exp_t e, got;
      bit   got_done;
      req_cycles   = 0;
      stall_cycles = 0;
      lat          = -1;
      got_done     = 1'b0;
      bus_we = 1'b0; bus_be = '0; bus_addr = '0; bus_wdata = '0;
      @(posedge clk); #1;
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      mem_if.mem_rdata = bus_rd;
      e.rdata = exp_rdata; e.fault = exp_fault; e.chk_rdata = chk_rdata;
      sb.push_back(e);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (stall) stall_cycles++;
         if (mem_if.mem_req) begin
            if (req_cycles == 0) begin
               bus_we    = mem_if.mem_we;
               bus_be    = mem_if.mem_be;
               bus_addr  = mem_if.mem_addr;
               bus_wdata = mem_if.mem_wdata;
            end
            mem_if.mem_ack = (req_cycles == ack_at);
            req_cycles++;
         end
         if (done) begin
            lat      = c;
            got_done = 1'b1;
            check({tag, "_sb_pending"}, 32'(sb.size()), 1);
            if (sb.size() > 0) begin
               got = sb.pop_front();
               check({tag, "_fault"}, 32'(fault), 32'(got.fault));
               if (got.chk_rdata) check({tag, "_rdata"}, 32'(rdata), 32'(got.rdata));
            end
            break;
         end
         @(posedge clk); #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         mem_if.mem_ack = 1'b0;
      end
      check({tag, "_done_seen"}, 32'(got_done), 1);
      if (got_done) begin
         @(negedge clk);
         check({tag, "_done_one_cycle"}, 32'(done), 0);
         if (chk_rdata) check({tag, "_rdata_hold"}, 32'(rdata), 32'(exp_rdata));
      end
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // LH, immediate ack.
      access("lh_imm", 1, 0, F3_H, 16'h0010, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 0, 1);
      check("lh_imm_addr",    32'(bus_addr), 32'h0008);
      check("lh_imm_be",      32'(bus_be), 32'(BE_ALL));
      check("lh_imm_we",      32'(bus_we), 0);
      check("lh_imm_stall",   32'(stall_cycles), 2);
      check("lh_imm_latency", 32'(lat), 2);

      // LB / LBU on the upper byte with three wait states.
      access("lb_hi", 1, 0, F3_B, 16'h0021, 16'h0000, 3, 16'h80AA, 16'hFF80, 0, 1);
      check("lb_hi_req_cycles", 32'(req_cycles), 4);
      check("lb_hi_latency",    32'(lat), 5);
      check("lb_hi_addr",       32'(bus_addr), 32'h0010);
      access("lbu_hi", 1, 0, F3_BU, 16'h0021, 16'h0000, 3, 16'h80AA, 16'h0080, 0, 1);
      check("lbu_hi_req_cycles", 32'(req_cycles), 4);

      // SB to the upper byte.
      access("sb_hi", 0, 1, F3_B, 16'h0033, 16'h1234, 0, 16'h0000, 16'h0000, 0, 0);
      check("sb_hi_we",    32'(bus_we), 1);
      check("sb_hi_be",    32'(bus_be), 32'h2);
      check("sb_hi_wdata", 32'(bus_wdata), 32'h3434);
      check("sb_hi_addr",  32'(bus_addr), 32'h0019);

      // SH full halfword.
      access("sh_al", 0, 1, F3_H, 16'h0044, 16'hA5C3, 1, 16'h0000, 16'h0000, 0, 0);
      check("sh_al_be",    32'(bus_be), 32'h3);
      check("sh_al_wdata", 32'(bus_wdata), 32'hA5C3);

      // Misaligned SH: no memory access, fault after one cycle.
      access("sh_mis", 0, 1, F3_H, 16'h0005, 16'h1111, 0, 16'h0000, 16'h0000, 1, 0);
      check("sh_mis_req",     32'(req_cycles), 0);
      check("sh_mis_latency", 32'(lat), 1);
      check("sh_mis_stall",   32'(stall_cycles), 1);

      // Other illegal requests.
      access("rd_wr", 1, 1, F3_B, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
      check("rd_wr_req", 32'(req_cycles), 0);
      access("bad_f3", 1, 0, 3'b010, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
      check("bad_f3_req", 32'(req_cycles), 0);
      access("sbu", 0, 1, F3_BU, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
      check("sbu_req", 32'(req_cycles), 0);

      // Timeout with no ack.
      access("tmo", 1, 0, F3_H, 16'h0040, 16'h0000, -1, 16'h5555, 16'h0000, 1, 1);
      check("tmo_req_cycles", 32'(req_cycles), 15);
      check("tmo_latency",    32'(lat), 16);

      // Ack on the last allowed cycle wins over the timeout.
      access("tmo_ack", 1, 0, F3_HU, 16'h0042, 16'h0000, 14, 16'h2468, 16'h2468, 0, 1);
      check("tmo_ack_req_cycles", 32'(req_cycles), 15);

      // mem_ack while idle is ignored.
      seen = 0;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || stall || mem_if.mem_req) seen++;
      end
      mem_if.mem_ack = 1'b0;
      check("idle_ack_ignored", 32'(seen), 0);

      // Reset in the second REQ cycle aborts without a done pulse.
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = F3_H; addr = 16'h0050;
      @(negedge clk);
      check("mid_rst_detect_stall", 32'(stall), 1);
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_req2", 32'(mem_if.mem_req), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("mid_rst");
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || mem_if.mem_req) seen++;
      end
      check("mid_rst_no_done", 32'(seen), 0);

      // A fresh LH after reset completes normally.
      access("lh_post", 1, 0, F3_H, 16'h0002, 16'h0000, 1, 16'h1357, 16'h1357, 0, 1);
      check("lh_post_latency", 32'(lat), 3);
      check("lh_post_addr",    32'(bus_addr), 32'h0001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
